// File: rtl/wb_regfile_hilo_if.sv
// Write-back to register-file bundle: WB commit buses, ID/EX read ports and the write counter.
// The master side is the pipeline (WB/ID); the slave side is the register file.
interface wb_regfile_hilo_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W+DATA_W:0]  wb_to_rf_bus;
    logic [2*DATA_W+1:0]     hilo_bus;
    logic [ADDR_W-1:0]       raddr1;
    logic [DATA_W-1:0]       rdata1;
    logic [ADDR_W-1:0]       raddr2;
    logic [DATA_W-1:0]       rdata2;
    logic [DATA_W-1:0]       hi_rdata;
    logic [DATA_W-1:0]       lo_rdata;
    logic [31:0]             wr_count;

    modport master (
        output wb_to_rf_bus, hilo_bus, raddr1, raddr2,
        input  rdata1, rdata2, hi_rdata, lo_rdata, wr_count
    );

    modport slave (
        input  wb_to_rf_bus, hilo_bus, raddr1, raddr2,
        output rdata1, rdata2, hi_rdata, lo_rdata, wr_count
    );
endinterface

// File: rtl/wb_regfile_hilo.sv
// GPR file plus HI/LO pair committed from the WB stage, with two combinational read
// ports and optional same-cycle write-to-read forwarding.
module wb_regfile_hilo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    wb_regfile_hilo_if.slave    bus
);
    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam bit          FWD  = (BYPASS != 0);

    logic [DATA_W-1:0] gpr [NREG];
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [31:0]       wr_count;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] hi_wdata;
    logic [DATA_W-1:0] lo_wdata;
    logic              gpr_wr;

    // Unpack the WB buses
    always_comb begin
        we       = bus.wb_to_rf_bus[ADDR_W+DATA_W];
        waddr    = bus.wb_to_rf_bus[DATA_W +: ADDR_W];
        wdata    = bus.wb_to_rf_bus[DATA_W-1:0];
        hi_we    = bus.hilo_bus[2*DATA_W+1];
        lo_we    = bus.hilo_bus[2*DATA_W];
        hi_wdata = bus.hilo_bus[DATA_W +: DATA_W];
        lo_wdata = bus.hilo_bus[DATA_W-1:0];
        gpr_wr   = we && (waddr != '0);
    end

    // Commit; reset wins over any write on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                gpr[i] <= '0;
            end
            hi       <= '0;
            lo       <= '0;
            wr_count <= '0;
        end else begin
            if (gpr_wr) begin
                gpr[waddr] <= wdata;
                wr_count   <= wr_count + 32'd1;
            end
            if (hi_we) begin
                hi <= hi_wdata;
            end
            if (lo_we) begin
                lo <= lo_wdata;
            end
        end
    end

    // Read ports; $0 is hard-wired to zero even when being written
    always_comb begin
        bus.rdata1   = '0;
        bus.rdata2   = '0;
        bus.hi_rdata = hi;
        bus.lo_rdata = lo;
        bus.wr_count = wr_count;
        if (bus.raddr1 != '0) begin
            bus.rdata1 = (FWD && we && (waddr == bus.raddr1)) ? wdata : gpr[bus.raddr1];
        end
        if (bus.raddr2 != '0) begin
            bus.rdata2 = (FWD && we && (waddr == bus.raddr2)) ? wdata : gpr[bus.raddr2];
        end
        if (FWD && hi_we) begin
            bus.hi_rdata = hi_wdata;
        end
        if (FWD && lo_we) begin
            bus.lo_rdata = lo_wdata;
        end
    end
endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Scoreboard bench for wb_regfile_hilo: directed cases then random traffic against a
// behavioural register-file model; a negedge monitor pops expectations and compares.
module tb_wb_regfile_hilo;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned BYPASS = 1;

    typedef struct {
        string       name;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    logic [31:0] m_gpr [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_cnt;

    wb_regfile_hilo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

    wb_regfile_hilo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_rd(input logic [4:0] a, input bit we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (BYPASS != 0 && we && wa == a) return wd;
        return m_gpr[a];
    endfunction

    task automatic apply(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input bit hwe, input bit lwe, input logic [31:0] hwd, input logic [31:0] lwd,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input bit chk, input string name);
        exp_t e;
        rst                 = r;
        bus_if.wb_to_rf_bus = {we, wa, wd};
        bus_if.hilo_bus     = {hwe, lwe, hwd, lwd};
        bus_if.raddr1       = a1;
        bus_if.raddr2       = a2;
        if (chk) begin
            e.name = name;
            e.r1   = model_rd(a1, we, wa, wd);
            e.r2   = model_rd(a2, we, wa, wd);
            e.hi   = (BYPASS != 0 && hwe) ? hwd : m_hi;
            e.lo   = (BYPASS != 0 && lwe) ? lwd : m_lo;
            e.cnt  = m_cnt;
            q.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            foreach (m_gpr[i]) m_gpr[i] = 32'd0;
            m_hi  = 32'd0;
            m_lo  = 32'd0;
            m_cnt = 32'd0;
        end else begin
            if (we && wa != 5'd0) begin
                m_gpr[wa] = wd;
                m_cnt     = m_cnt + 32'd1;
            end
            if (hwe) m_hi = hwd;
            if (lwe) m_lo = lwd;
        end
        #1;
    endtask

    task automatic cmp(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so each queued expectation is due at the next negedge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, "rdata1",   bus_if.rdata1,   e.r1);
                cmp(e.name, "rdata2",   bus_if.rdata2,   e.r2);
                cmp(e.name, "hi_rdata", bus_if.hi_rdata, e.hi);
                cmp(e.name, "lo_rdata", bus_if.lo_rdata, e.lo);
                cmp(e.name, "wr_count", bus_if.wr_count, e.cnt);
            end
        end
    end

    initial begin
        logic [4:0]  wa;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] wd;
        bit          we;
        bit          hwe;
        bit          lwe;

        foreach (m_gpr[i]) m_gpr[i] = 32'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        m_cnt = 32'd0;

        apply(1, 0, 5'd0, 32'd0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 0, "reset");
        for (int i = 0; i < 16; i++) begin
            a1 = 5'(2 * i);
            a2 = 5'(2 * i + 1);
            apply(0, 0, 5'd0, 32'd0, 0, 0, 32'd0, 32'd0, a1, a2, 1, "reset_read");
        end

        apply(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 32'd0, 32'd0, 5'd5, 5'd0, 1, "wr5_bypass");
        apply(0, 0, 5'd0, 32'd0,        0, 0, 32'd0, 32'd0, 5'd5, 5'd5, 1, "wr5_after");

        apply(0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 1, "wr0_same");
        apply(0, 0, 5'd0, 32'd0,        0, 0, 32'd0, 32'd0, 5'd0, 5'd5, 1, "wr0_after");

        apply(0, 1, 5'd7, 32'h12345678, 0, 0, 32'd0, 32'd0, 5'd7, 5'd7, 1, "dual7");
        apply(0, 1, 5'd7, 32'h12345678, 0, 0, 32'd0, 32'd0, 5'd7, 5'd8, 1, "dual7_8");
        apply(0, 0, 5'd0, 32'd0,        0, 0, 32'd0, 32'd0, 5'd7, 5'd8, 1, "dual_after");

        apply(0, 0, 5'd0, 32'd0, 1, 0, 32'hAAAA0000, 32'h5555, 5'd0, 5'd0, 1, "mthi");
        apply(0, 0, 5'd0, 32'd0, 1, 1, 32'h1, 32'h2,           5'd0, 5'd0, 1, "mult");
        apply(0, 0, 5'd0, 32'd0, 0, 0, 32'd0, 32'd0,           5'd0, 5'd0, 1, "hilo_after");
        apply(0, 0, 5'd0, 32'd0, 0, 1, 32'h0, 32'hCAFE0001,    5'd0, 5'd0, 1, "mtlo");

        apply(0, 1, 5'd9, 32'h0BADF00D, 1, 1, 32'h77, 32'h88,  5'd9, 5'd5, 1, "gpr_hilo");
        apply(0, 0, 5'd0, 32'd0, 0, 0, 32'd0, 32'd0,           5'd9, 5'd5, 1, "bubble");

        apply(1, 1, 5'd3, 32'd9, 1, 0, 32'h99, 32'd0, 5'd3, 5'd5, 1, "rst_vs_wr");
        apply(0, 0, 5'd0, 32'd0, 0, 0, 32'd0, 32'd0, 5'd3, 5'd9, 1, "rst_after");

        for (int n = 0; n < 400; n++) begin
            we  = ($urandom_range(0, 3) != 0);
            wa  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            wd  = $urandom;
            hwe = ($urandom_range(0, 3) == 0);
            lwe = ($urandom_range(0, 3) == 0);
            a1  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) begin
                apply(0, 0, 5'd0, 32'd0, 0, 0, 32'd0, 32'd0, a1, a2, 1, "rand_bubble");
            end else begin
                apply(0, we, wa, wd, hwe, lwe, $urandom, $urandom, a1, a2, 1, "rand");
            end
        end

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
